// File: rtl/alu_cmd_sequencer.sv
// Purpose : valid/ready front end for a single-adder combinational ALU, with optional accumulate.
// Latency : command accepted at edge N -> rsp_valid high after edge N+1; 3 cycles minimum per command.
// Backpr. : response is held stable while rsp_ready=0; cmd_ready stays low until the response is taken.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command channel: cmd_a, cmd_b, cmd_op (00 add, 01 sub, 10 and, 11 or), cmd_acc
//   alu_a/alu_b/alu_control  registered drive to the external ALU; alu_y is its combinational result
//   rsp_valid/rsp_ready      response channel: rsp_y, rsp_op, rsp_zero
//   op_count                 accepted-response counter, wraps at 2^CW
module alu_cmd_sequencer #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [1:0]    cmd_op,
  input  logic          cmd_acc,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_control,
  input  logic [DW-1:0] alu_y,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_y,
  output logic [1:0]    rsp_op,
  output logic          rsp_zero,
  output logic [CW-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [1:0]    alu_ctrl_q, alu_ctrl_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] rsp_y_q, rsp_y_d;
  logic [1:0]    rsp_op_q, rsp_op_d;
  logic          rsp_zero_q, rsp_zero_d;
  logic [CW-1:0] op_count_q, op_count_d;

  // Gated with rst so ready reads low for the whole reset cycle, even though
  // the state register already sits in IDLE.
  assign cmd_ready   = (state_q == S_IDLE) && !rst;
  assign rsp_valid   = (state_q == S_RESP);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctrl_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_zero    = rsp_zero_q;
  assign op_count    = op_count_q;

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    acc_d      = acc_q;
    rsp_y_d    = rsp_y_q;
    rsp_op_d   = rsp_op_q;
    rsp_zero_d = rsp_zero_q;
    op_count_d = op_count_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          alu_a_d    = cmd_acc ? acc_q : cmd_a;
          alu_b_d    = cmd_b;
          alu_ctrl_d = cmd_op;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        // ALU inputs have been stable since the last edge; capture its result.
        rsp_y_d    = alu_y;
        acc_d      = alu_y;
        rsp_op_d   = alu_ctrl_q;
        rsp_zero_d = (alu_y == '0);
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + {{(CW-1){1'b0}}, 1'b1};
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= 2'b00;
      acc_q      <= '0;
      rsp_y_q    <= '0;
      rsp_op_q   <= 2'b00;
      rsp_zero_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      acc_q      <= acc_d;
      rsp_y_q    <= rsp_y_d;
      rsp_op_q   <= rsp_op_d;
      rsp_zero_q <= rsp_zero_d;
      op_count_q <= op_count_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Purpose : self-checking bench for alu_cmd_sequencer with a behavioural ALU attached.
// Latency : n/a (testbench).
// Backpr. : drives rsp_ready low for several cycles in a dedicated sequence.
module tb_alu_cmd_sequencer;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic [1:0]    cmd_op;
  logic          cmd_acc;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_control;
  logic [DW-1:0] alu_y;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_y;
  logic [1:0]    rsp_op;
  logic          rsp_zero;
  logic [CW-1:0] op_count;

  int checks;
  int failures;
  logic [CW-1:0] exp_cnt;

  alu_cmd_sequencer #(.DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .cmd_acc     (cmd_acc),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_y       (alu_y),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_y       (rsp_y),
    .rsp_op      (rsp_op),
    .rsp_zero    (rsp_zero),
    .op_count    (op_count)
  );

  // Behavioural stand-in for the attached combinational ALU.
  always_comb begin
    case (alu_control)
      2'b00:   alu_y = alu_a + alu_b;
      2'b01:   alu_y = alu_a - alu_b;
      2'b10:   alu_y = alu_a & alu_b;
      default: alu_y = alu_a | alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        acc;
    logic [31:0] exp_a;
    logic [31:0] exp_y;
    logic        exp_z;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one command with rsp_ready already high and checks the whole
  // round trip: EXEC operands, 2-cycle latency, payload and counter.
  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic acc,
                      input logic [31:0] exp_a, input logic [31:0] exp_y, input logic exp_z);
    int g;
    int lat;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_acc   = acc;
    cmd_valid = 1'b1;
    #1;
    g = 0;
    while (!cmd_ready && g < 20) begin
      tick();
      g++;
    end
    chk({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, " exec alu_a"}, alu_a, exp_a);
    chk({tag, " exec alu_ctrl"}, {30'd0, alu_control}, {30'd0, op});
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, 32'd2);
    chk({tag, " rsp_y"}, rsp_y, exp_y);
    chk({tag, " rsp_op"}, {30'd0, rsp_op}, {30'd0, op});
    chk({tag, " rsp_zero"}, {31'd0, rsp_zero}, {31'd0, exp_z});
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk({tag, " op_count"}, {28'd0, op_count}, {28'd0, exp_cnt});
    chk({tag, " back idle"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int g;
    checks    = 0;
    failures  = 0;
    exp_cnt   = '0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = 2'b00;
    cmd_acc   = 1'b0;
    rsp_ready = 1'b0;

    //          a            b       op    acc   exp_a   exp_y          z
    vecs[0]  = '{32'd0,       32'd5,  2'd0, 1'b0, 32'd0,  32'd5,         1'b0};
    vecs[1]  = '{32'd0,       32'd5,  2'd1, 1'b0, 32'd0,  32'hFFFFFFFB,  1'b0};
    vecs[2]  = '{32'd0,       32'd5,  2'd2, 1'b0, 32'd0,  32'd0,         1'b1};
    vecs[3]  = '{32'd0,       32'd5,  2'd3, 1'b0, 32'd0,  32'd5,         1'b0};
    vecs[4]  = '{32'd10,      32'd20, 2'd0, 1'b0, 32'd10, 32'd30,        1'b0};
    vecs[5]  = '{32'd10,      32'd20, 2'd1, 1'b0, 32'd10, 32'hFFFFFFF6,  1'b0};
    vecs[6]  = '{32'd10,      32'd20, 2'd2, 1'b0, 32'd10, 32'd0,         1'b1};
    vecs[7]  = '{32'd10,      32'd20, 2'd3, 1'b0, 32'd10, 32'd30,        1'b0};
    vecs[8]  = '{32'd10,      32'd20, 2'd0, 1'b0, 32'd10, 32'd30,        1'b0};
    vecs[9]  = '{32'hDEADBEEF, 32'd5, 2'd0, 1'b1, 32'd30, 32'd35,        1'b0};
    vecs[10] = '{32'h00001234, 32'd35, 2'd1, 1'b1, 32'd35, 32'd0,        1'b1};

    // Reset values, including ready held low while rst is high.
    tick();
    tick();
    chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst rsp_y", rsp_y, 32'd0);
    chk("rst rsp_op", {30'd0, rsp_op}, 32'd0);
    chk("rst rsp_zero", {31'd0, rsp_zero}, 32'd0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst alu_ctrl", {30'd0, alu_control}, 32'd0);
    chk("rst op_count", {28'd0, op_count}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post-rst cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // rsp_ready high ahead of any response; must not disturb anything.
    rsp_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].acc,
           vecs[i].exp_a, vecs[i].exp_y, vecs[i].exp_z);
      if (i == 7) chk("count after 8", {28'd0, op_count}, 32'd8);
    end

    // Backpressure with a second command waiting on cmd_valid throughout.
    rsp_ready = 1'b0;
    cmd_a = 32'd3; cmd_b = 32'd4; cmd_op = 2'b00; cmd_acc = 1'b0; cmd_valid = 1'b1;
    #1;
    g = 0;
    while (!cmd_ready && g < 20) begin
      tick();
      g++;
    end
    chk("bp accept", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_a = 32'd100; cmd_b = 32'd1;
    chk("bp exec ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d rsp_y", k), rsp_y, 32'd7);
      chk($sformatf("bp%0d rsp_op", k), {30'd0, rsp_op}, 32'd0);
      chk($sformatf("bp%0d cmd_ready", k), {31'd0, cmd_ready}, 32'd0);
      chk($sformatf("bp%0d op_count", k), {28'd0, op_count}, {28'd0, exp_cnt});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    chk("bp release count", {28'd0, op_count}, {28'd0, exp_cnt});
    chk("bp release ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("bp next alu_a", alu_a, 32'd100);
    tick();
    chk("bp next rsp_y", rsp_y, 32'd101);
    rsp_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("bp next count", {28'd0, op_count}, {28'd0, exp_cnt});

    // Reset during EXEC discards the result and clears acc and counter.
    cmd_a = 32'd1; cmd_b = 32'd1; cmd_op = 2'b00; cmd_acc = 1'b0; cmd_valid = 1'b1;
    #1;
    chk("midrst accept", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("midrst exec alu_a", alu_a, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    exp_cnt = '0;
    chk("midrst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst op_count", {28'd0, op_count}, 32'd0);
    chk("midrst rsp_y", rsp_y, 32'd0);
    chk("midrst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    send("acc after rst", 32'h00000999, 32'd7, 2'b00, 1'b1, 32'd0, 32'd7, 1'b0);

    // ALU operands hold while IDLE regardless of cmd_* activity.
    cmd_a = 32'h0000ABCD; cmd_b = 32'h00005555; cmd_op = 2'b11;
    tick();
    tick();
    chk("idle hold alu_a", alu_a, 32'd0);
    chk("idle hold alu_b", alu_b, 32'd7);
    chk("idle hold ctrl", {30'd0, alu_control}, 32'd0);

    // Counter wrap: 16 responses from zero return op_count to zero.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      send($sformatf("wrap%0d", i), i, 32'd1, 2'b00, 1'b0, i, i + 1, 1'b0);
      if (i == 14) chk("wrap at max", {28'd0, op_count}, 32'd15);
    end
    chk("wrap to zero", {28'd0, op_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
